dm_copy_engine: RTL and testbench
=================================

# dm_copy_engine

Word-granular block-copy initiator for the 1K×32 big-endian, byte-addressed data memory. On a start pulse it checks the request, then copies `word_cnt` 32-bit words from `src_addr` to `dst_addr`. Each word takes one read cycle and one write cycle on the memory's chip-select/read/write port. It sits beside the CPU datapath as the memory's second initiator; the top-level arbitration muxes it onto the memory while `busy` is high.

## Interface
- `MEM_BYTES`, default 4096: memory size in bytes, used for range checking.
- `CNT_W`, default 11: width of `word_cnt`, covering 0..1024 words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe, sampled only in IDLE.
- `src_addr`  in  32  source byte address, sampled with `start`.
- `dst_addr`  in  32  destination byte address, sampled with `start`.
- `word_cnt`  in  CNT_W  number of words to copy, sampled with `start`.
- `busy`  out  1  high in READ, WRITE and DONE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` when the request was rejected.
- `dm_cs`  out  1  memory chip select.
- `dm_rd`  out  1  memory read enable.
- `dm_wr`  out  1  memory write enable.
- `dm_addr`  out  32  memory byte address.
- `dm_dout`  out  32  write data to the memory's `D_in`.
- `dm_din`  in  32  read data from the memory's `D_out`; valid combinationally while `dm_cs` and `dm_rd` are high.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE, `start` high:** latch `src_ptr`, `dst_ptr` and `remaining` from the inputs. Classify the request:
  - Reject if `src_addr[1:0]` ≠ 0, or `dst_addr[1:0]` ≠ 0, or `addr + 4*word_cnt` > `MEM_BYTES` for either address. Comparisons are done at 33 bits, so wrap-around counts as out of range. Go to DONE with `err_q` set.
  - If `word_cnt` = 0 (and not rejected), go to DONE with `err_q` clear.
  - Otherwise go to READ.
- **READ:** `dm_cs` = `dm_rd` = 1, `dm_addr` = `src_ptr`. At the edge, `data_q` <= `dm_din`; go to WRITE.
- **WRITE:** `dm_cs` = `dm_wr` = 1, `dm_addr` = `dst_ptr`, `dm_dout` = `data_q`. The memory commits at this edge. Then:
  - `src_ptr` += 4, `dst_ptr` += 4, `remaining` -= 1.
  - If `remaining` was 1, go to DONE; otherwise go to READ.
- **DONE:** `done` = 1, `err` = `err_q`. Go to IDLE unconditionally.
- **Outputs outside READ/WRITE:** `dm_cs`/`dm_rd`/`dm_wr` = 0, `dm_addr` = 0, `dm_dout` = 0. `dm_rd` and `dm_wr` are never high together.
- **Memory outputs are Moore:** decoded from state and registered pointers only, so there is no combinational path from `start` to the memory port.
- **`start` while busy:** ignored, not queued.
- **Overlapping regions:** the copy is always ascending. If `dst` > `src` and the regions overlap, source words are overwritten before they are read; this is the defined behaviour.
- **Reset mid-copy:** immediately returns to IDLE with all outputs 0. Words already written stay in memory; no `done` pulse is issued.

## Timing
- Reset values: `busy`, `done`, `err`, `dm_cs`, `dm_rd`, `dm_wr`, `dm_addr`, `dm_dout` all 0. State is IDLE; `data_q`, pointers and `remaining` are 0.
- `start` is sampled at edge E0. Word i is read in the cycle after E(2i) and written at edge E(2i+2).
- For N ≥ 1, `done` is high in the cycle after E(2N). `busy` is high from E0 until E(2N+1). Total latency from start to done is 2N+1 cycles.
- For a zero-count or rejected request, `done` (and `err` if rejected) is high in the cycle after E0. `busy` is high for exactly that one cycle.
- A new `start` is accepted at E(2N+1) or any later edge.

## Structure
- Package `dm_pkg` holds:
  - the state enum (IDLE/READ/WRITE/DONE, 2 bits);
  - `WORD_BYTES` = 4;
  - the default `MEM_BYTES` = 4096.
- Single module; no sub-module required. The range/alignment check stays a local combinational block.
- The bench instantiates the team's 1K×32 data memory as the responder.

## Test plan
- **Reset:** hold `reset_n` low and toggle `clk` → every output is 0; state is IDLE after release.
- **3-word copy:** preload words 0x11111111, 0x22222222, 0x33333333 at 0x000; start with src=0x000, dst=0x100, cnt=3 → 0x100..0x10B hold the same words. `done` is high in the cycle after E6, `err` = 0. `busy` is high for 7 cycles.
- **Zero count and reject:** cnt=0 → `done` is high in the cycle after E0, no `dm_cs` activity. src=0x002, cnt=1 → `done` = `err` = 1, no `dm_cs` activity.
- **Range limit:** src=0xFFC, dst=0x000, cnt=1 → copies one word, `err` = 0. src=0xFFC, cnt=2 → `err` = 1, no access.
- **Overlap and ignored start:** src=0x000, dst=0x004, cnt=2 with words A,B at 0x000 → 0x004 = A and 0x008 = A. Pulsing `start` at E2 has no effect.
- **Reset mid-copy:** cnt=4, assert `reset_n` low at E3 → outputs drop to 0 at once. The word at dst+0 is written, dst+4 is unchanged, and no `done` pulse occurs.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory block-copy engine.
package dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dm_state_e;

   localparam int unsigned WORD_BYTES   = 4;
   localparam int unsigned DM_MEM_BYTES = 4096;

endpackage

// File: rtl/dm_copy_engine.sv
// Word-granular block-copy initiator: one read cycle then one write cycle per word,
// ascending addresses, with alignment and range rejection of the request.
module dm_copy_engine
   import dm_pkg::*;
#(
   parameter int unsigned MEM_BYTES = DM_MEM_BYTES,
   parameter int unsigned CNT_W     = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] word_cnt,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             dm_cs,
   output logic             dm_rd,
   output logic             dm_wr,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_dout,
   input  logic [31:0]      dm_din
);

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
   localparam logic [31:0] PTR_STEP  = 32'(WORD_BYTES);

   dm_state_e        state_q, state_d;
   logic [31:0]      src_ptr_q, src_ptr_d;
   logic [31:0]      dst_ptr_q, dst_ptr_d;
   logic [31:0]      data_q, data_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             err_q, err_d;

   logic [32:0]      span;
   logic [32:0]      src_end;
   logic [32:0]      dst_end;
   logic             reject;

   // Ends are formed at 33 bits so a request that wraps past 2^32 is out of range.
   always_comb begin
      span    = 33'(word_cnt) * 33'(WORD_BYTES);
      src_end = {1'b0, src_addr} + span;
      dst_end = {1'b0, dst_addr} + span;
      reject  = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) ||
                (src_end > MEM_LIMIT)    || (dst_end > MEM_LIMIT);
   end

   always_comb begin
      state_d     = state_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_ptr_d   = src_addr;
               dst_ptr_d   = dst_addr;
               remaining_d = word_cnt;
               err_d       = reject;
               if (reject || (word_cnt == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            data_d  = dm_din;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            src_ptr_d   = src_ptr_q + PTR_STEP;
            dst_ptr_d   = dst_ptr_q + PTR_STEP;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         data_q      <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         err_q       <= err_d;
      end
   end

   // Memory port is decoded from registered state only, keeping start off the memory path.
   always_comb begin
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_DONE);
      err     = (state_q == ST_DONE) && err_q;
      dm_cs   = 1'b0;
      dm_rd   = 1'b0;
      dm_wr   = 1'b0;
      dm_addr = '0;
      dm_dout = '0;
      case (state_q)
         ST_READ: begin
            dm_cs   = 1'b1;
            dm_rd   = 1'b1;
            dm_addr = src_ptr_q;
         end
         ST_WRITE: begin
            dm_cs   = 1'b1;
            dm_wr   = 1'b1;
            dm_addr = dst_ptr_q;
            dm_dout = data_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Scoreboard bench for dm_copy_engine against a 1Kx32 word memory responder.
module tb_dm_copy_engine;

   localparam int CNT_W = 11;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [CNT_W-1:0] word_cnt;
   logic             busy;
   logic             done;
   logic             err;
   logic             dm_cs;
   logic             dm_rd;
   logic             dm_wr;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_dout;
   logic [31:0]      dm_din;

   dm_copy_engine #(.MEM_BYTES(4096), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .word_cnt (word_cnt),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .dm_cs    (dm_cs),
      .dm_rd    (dm_rd),
      .dm_wr    (dm_wr),
      .dm_addr  (dm_addr),
      .dm_dout  (dm_dout),
      .dm_din   (dm_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder with a side preload port; model mirrors the intended contents.
   logic [31:0] mem   [0:1023];
   logic [31:0] model [0:1023];
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (dm_cs && dm_wr) mem[dm_addr[11:2]] <= dm_dout;
   end
   assign dm_din = (dm_cs && dm_rd) ? mem[dm_addr[11:2]] : 32'h0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          kind;   // 0 read, 1 write, 2 done
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
      logic        err;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev;
   int  obs_kind;
   int  busy_cnt = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (busy) busy_cnt++;
         if (dm_cs || done) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_op", {29'd0, dm_cs, dm_wr, done}, 32'd0);
            end else begin
               ev = exp_q.pop_front();
               obs_kind = done ? (dm_cs ? 4 : 2) :
                          (dm_wr ? (dm_rd ? 5 : 1) : (dm_rd ? 0 : 3));
               check_eq("op_kind", 32'(obs_kind), 32'(ev.kind));
               check_eq("op_cycle", 32'(cyc), 32'(ev.cyc));
               if (ev.kind == 2) begin
                  check_eq("done_err", {31'd0, err}, {31'd0, ev.err});
                  check_eq("done_addr", dm_addr, 32'h0);
               end else begin
                  check_eq("op_addr", dm_addr, ev.addr);
                  if (ev.kind == 1) check_eq("wdata", dm_dout, ev.data);
               end
            end
         end
      end
   end

   task automatic poke_word(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_idx  = addr[11:2];
      pl_data = data;
      model[addr[11:2]] = data;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_err"},  {31'd0, err},  32'd0);
      check_eq({tag, "_cs"},   {31'd0, dm_cs}, 32'd0);
      check_eq({tag, "_rd"},   {31'd0, dm_rd}, 32'd0);
      check_eq({tag, "_wr"},   {31'd0, dm_wr}, 32'd0);
      check_eq({tag, "_addr"}, dm_addr, 32'd0);
      check_eq({tag, "_dout"}, dm_dout, 32'd0);
   endtask

   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input bit exp_err, input int poke_edge, input int rst_edge);
      int  c0;
      int  budget;
      bit  keep;
      ev_t e;
      logic [31:0] w;
      logic [9:0]  si, di;
      @(negedge clk);
      src_addr = src;
      dst_addr = dst;
      word_cnt = CNT_W'(cnt);
      start    = 1'b1;
      c0       = cyc + 1;
      busy_cnt = 0;
      if (exp_err || cnt == 0) begin
         e = '{kind: 2, addr: 32'h0, data: 32'h0, cyc: c0, err: exp_err};
         exp_q.push_back(e);
      end else begin
         for (int i = 0; i < cnt; i++) begin
            si = 10'((src >> 2) + 32'(i));
            di = 10'((dst >> 2) + 32'(i));
            w  = model[si];
            keep = (rst_edge < 0) || (c0 + 2 * i < c0 + rst_edge);
            if (keep) begin
               e = '{kind: 0, addr: src + 32'(4 * i), data: 32'h0, cyc: c0 + 2 * i, err: 1'b0};
               exp_q.push_back(e);
            end
            keep = (rst_edge < 0) || (c0 + 2 * i + 1 < c0 + rst_edge);
            if (keep) begin
               e = '{kind: 1, addr: dst + 32'(4 * i), data: w, cyc: c0 + 2 * i + 1, err: 1'b0};
               exp_q.push_back(e);
               model[di] = w;
            end
         end
         if (rst_edge < 0) begin
            e = '{kind: 2, addr: 32'h0, data: 32'h0, cyc: c0 + 2 * cnt, err: 1'b0};
            exp_q.push_back(e);
         end
      end
      $display("copy src=%08h dst=%08h cnt=%0d exp_err=%0b", src, dst, cnt, exp_err);
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_addr = 32'hDEAD_0000;
      dst_addr = 32'hBEEF_0000;
      word_cnt = CNT_W'(7);
      budget   = 2 * cnt + 8;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (k == poke_edge) begin
            start    = 1'b1;
            src_addr = 32'h0000_0800;
            dst_addr = 32'h0000_0900;
            word_cnt = CNT_W'(5);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         if (k == rst_edge) begin
            #1 reset_n = 1'b0;
            break;
         end
         if (exp_q.size() == 0) break;
      end
      start = 1'b0;
      if (rst_edge >= 0) begin
         @(negedge clk);
         check_idle("rst_mid");
         check_eq("rst_pending", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         repeat (2) @(negedge clk);
         reset_n = 1'b1;
         @(negedge clk);
         check_eq("rst_dst0", mem[10'(dst >> 2)], model[10'(dst >> 2)]);
         check_eq("rst_dst1", mem[10'((dst >> 2) + 1)], model[10'((dst >> 2) + 1)]);
      end else begin
         check_eq("timeout_left", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         @(negedge clk);
         check_eq("busy_after", {31'd0, busy}, 32'd0);
         check_eq("done_after", {31'd0, done}, 32'd0);
         check_eq("busy_cycles", 32'(busy_cnt), (exp_err || cnt == 0) ? 32'd1 : 32'(2 * cnt + 1));
         if (!exp_err) begin
            for (int i = 0; i <= cnt && (int'(dst >> 2) + i) < 1024; i++) begin
               di = 10'((dst >> 2) + 32'(i));
               check_eq("mem_word", mem[di], model[di]);
            end
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      word_cnt = '0;
      pl_en    = 1'b0;
      pl_idx   = '0;
      pl_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      for (int i = 0; i < 1024; i++) poke_word(32'(4 * i), 32'hC0DE_0000 | 32'(i));

      poke_word(32'h000, 32'h1111_1111);
      poke_word(32'h004, 32'h2222_2222);
      poke_word(32'h008, 32'h3333_3333);
      run_copy(32'h000, 32'h100, 3, 1'b0, -1, -1);
      check_eq("copy3_w0", mem[10'h040], 32'h1111_1111);
      check_eq("copy3_w2", mem[10'h042], 32'h3333_3333);

      run_copy(32'h200, 32'h300, 0, 1'b0, -1, -1);
      run_copy(32'h002, 32'h100, 1, 1'b1, -1, -1);
      run_copy(32'h000, 32'h101, 1, 1'b1, -1, -1);
      run_copy(32'hFFC, 32'h000, 1, 1'b0, -1, -1);
      run_copy(32'hFFC, 32'h400, 2, 1'b1, -1, -1);
      run_copy(32'hFFFF_FFFC, 32'h000, 2, 1'b1, -1, -1);
      run_copy(32'h000, 32'hFFC, 2, 1'b1, -1, -1);

      poke_word(32'h000, 32'hAAAA_0001);
      poke_word(32'h004, 32'hBBBB_0002);
      run_copy(32'h000, 32'h004, 2, 1'b0, 2, -1);
      check_eq("overlap_w1", mem[10'h001], 32'hAAAA_0001);
      check_eq("overlap_w2", mem[10'h002], 32'hAAAA_0001);

      run_copy(32'h040, 32'h200, 4, 1'b0, -1, 3);
      run_copy(32'h080, 32'h280, 1, 1'b0, -1, -1);
      run_copy(32'h000, 32'h000, 1024, 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
